// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit and data memory.
//   bus_req   : unit -> mem, transfer requested (held until ack or abort)
//   bus_we    : unit -> mem, 1 = write
//   bus_addr  : unit -> mem, word-aligned byte address
//   bus_be    : unit -> mem, byte enables (bit i = byte lane i)
//   bus_wdata : unit -> mem, lane-replicated store data
//   bus_ack   : mem -> unit, transfer completes this cycle
//   bus_rdata : mem -> unit, read word, valid with bus_ack
interface mem_access_unit_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit.
// Checks alignment of a load/store, drives one req/ack transfer on the data
// bus while stalling the pipeline, and hands the raw read word (plus byte
// offset and extend op) to the downstream load-data extender.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   req_valid/we/addr/wdata/op : pipeline request (op: 000 w, 001 bu, 010 b,
//                           011 hu, 100 h; 101-111 behave as word)
//   stall                 : combinational pipeline hold
//   mem (master)          : data bus, see mem_access_unit_if
//   ld_valid/ld_data/ld_a/ld_op : one-cycle load result for the extender
//   adel / ades           : misaligned load / store exception pulses
//   bus_err               : bus timeout abort pulse
module mem_access_unit #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   input  logic                req_we,
   input  logic [31:0]         req_addr,
   input  logic [31:0]         req_wdata,
   input  logic [2:0]          req_op,
   output logic                stall,
   mem_access_unit_if.master   mem,
   output logic                ld_valid,
   output logic [31:0]         ld_data,
   output logic [1:0]          ld_a,
   output logic [2:0]          ld_op,
   output logic                adel,
   output logic                ades,
   output logic                bus_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nx;
   logic [CNT_W-1:0] cnt;

   logic        we_q;
   logic [31:0] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wd_q;
   logic [1:0]  pend_a;
   logic [2:0]  pend_op;

   logic        is_byte, is_half, is_word;
   logic        aligned, accept, mis, timeout_hit;
   logic [3:0]  be_nx;
   logic [31:0] wd_nx;

   // Size decode; unused op codes fall through to word.
   assign is_byte = (req_op == 3'b001) || (req_op == 3'b010);
   assign is_half = (req_op == 3'b011) || (req_op == 3'b100);
   assign is_word = !is_byte && !is_half;

   assign aligned = is_byte
                  | (is_half & ~req_addr[0])
                  | (is_word & (req_addr[1:0] == 2'b00));

   assign accept = (state == IDLE) && req_valid && aligned;
   // While an exception pulse is out the pipeline is flushing the same
   // request, so it must not raise the exception a second time.
   assign mis    = (state == IDLE) && req_valid && !aligned && !(adel || ades);

   assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

   assign stall = accept || (state == BUSY);

   always_comb begin
      be_nx = 4'b1111;
      wd_nx = 32'h0;
      if (req_we) begin
         if (is_byte) begin
            be_nx = 4'b0001 << req_addr[1:0];
            wd_nx = {4{req_wdata[7:0]}};
         end else if (is_half) begin
            be_nx = req_addr[1] ? 4'b1100 : 4'b0011;
            wd_nx = {2{req_wdata[15:0]}};
         end else begin
            wd_nx = req_wdata;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = BUSY;
         BUSY:    if (mem.bus_ack || timeout_hit) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // bus_req decodes straight from state, so an async reset drops it at once.
   assign mem.bus_req   = (state == BUSY);
   assign mem.bus_we    = we_q;
   assign mem.bus_addr  = addr_q;
   assign mem.bus_be    = be_q;
   assign mem.bus_wdata = wd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         we_q     <= 1'b0;
         addr_q   <= 32'h0;
         be_q     <= 4'h0;
         wd_q     <= 32'h0;
         pend_a   <= 2'b00;
         pend_op  <= 3'b000;
         ld_valid <= 1'b0;
         ld_data  <= 32'h0;
         ld_a     <= 2'b00;
         ld_op    <= 3'b000;
         adel     <= 1'b0;
         ades     <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         ld_valid <= 1'b0;
         adel     <= 1'b0;
         ades     <= 1'b0;
         bus_err  <= 1'b0;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= {req_addr[31:2], 2'b00};
            be_q    <= be_nx;
            wd_q    <= wd_nx;
            pend_a  <= req_addr[1:0];
            pend_op <= req_op;
            cnt     <= '0;
         end
         if (mis) begin
            adel <= !req_we;
            ades <= req_we;
         end
         if (state == BUSY) begin
            cnt <= cnt + CNT_W'(1);
            // Ack beats a simultaneous timeout.
            if (mem.bus_ack) begin
               if (!we_q) begin
                  ld_valid <= 1'b1;
                  ld_data  <= mem.bus_rdata;
                  ld_a     <= pend_a;
                  ld_op    <= pend_op;
               end
            end else if (timeout_hit) begin
               bus_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_op = '0;
   logic        stall;
   logic        ld_valid, adel, ades, bus_err;
   logic [31:0] ld_data;
   logic [1:0]  ld_a;
   logic [2:0]  ld_op;

   mem_access_unit_if mif ();

   mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_op(req_op),
      .stall(stall), .mem(mif.master),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_a(ld_a), .ld_op(ld_op),
      .adel(adel), .ades(ades), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard of expected one-cycle events: 1 load, 2 adel, 3 ades, 4 bus_err.
   typedef struct {
      int          kind;
      logic [31:0] data;
      logic [1:0]  a;
      logic [2:0]  op;
   } ev_t;
   ev_t sb[$];
   ev_t mon_e;
   int  mon_k;

   function automatic ev_t mk(input int k, input logic [31:0] d, input logic [1:0] a, input logic [2:0] op);
      ev_t e;
      e.kind = k; e.data = d; e.a = a; e.op = op;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         mon_k = ld_valid ? 1 : adel ? 2 : ades ? 3 : bus_err ? 4 : 0;
         if (mon_k != 0) begin
            if (sb.size() == 0) chk("ev_unexpected", mon_k, 0);
            else begin
               mon_e = sb.pop_front();
               chk("ev_kind", mon_k, mon_e.kind);
               if (mon_k == 1) begin
                  chk("ld_data", ld_data, mon_e.data);
                  chk("ld_a", {30'h0, ld_a}, {30'h0, mon_e.a});
                  chk("ld_op", {29'h0, ld_op}, {29'h0, mon_e.op});
               end
            end
         end
      end
   end

   initial mif.bus_ack = 1'b0;
   initial mif.bus_rdata = '0;

   // One aligned access. ack_at = BUSY cycle (1-based) carrying the ack,
   // 0 = never ack (timeout expected after TO cycles).
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] op, input int ack_at, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd);
      int n;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_op = op;
      @(negedge clk);
      chk("stall_idle", stall, 1);
      chk("req_idle", mif.bus_req, 0);
      @(posedge clk); #1;
      n = 1;
      forever begin
         if (n == ack_at) begin
            mif.bus_ack = 1'b1; mif.bus_rdata = rdata;
         end
         @(negedge clk);
         chk("bus_req", mif.bus_req, 1);
         chk("stall_busy", stall, 1);
         chk("bus_addr", mif.bus_addr, {addr[31:2], 2'b00});
         chk("bus_be", {28'h0, mif.bus_be}, {28'h0, exp_be});
         chk("bus_wdata", mif.bus_wdata, exp_wd);
         chk("bus_we", mif.bus_we, we);
         @(posedge clk); #1;
         mif.bus_ack = 1'b0;
         if (n == ack_at || (ack_at == 0 && n == TO)) break;
         n++;
         if (n > 300) begin
            chk("busy_bound", n, 0);
            break;
         end
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk("stall_done", stall, 0);
      chk("req_done", mif.bus_req, 0);
   endtask

   task automatic do_mis(input logic we, input logic [31:0] addr, input logic [2:0] op);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = 32'h55; req_op = op;
      @(negedge clk);
      chk("stall_mis", stall, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("req_mis", mif.bus_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("exc_clear", {30'h0, adel, ades}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", mif.bus_req, 0);
      chk("rst_addr", mif.bus_addr, 0);
      chk("rst_be", {28'h0, mif.bus_be}, 0);
      chk("rst_ld", {ld_valid, adel, ades, bus_err}, 0);
      chk("rst_ld_data", ld_data, 0);
      rst_n = 1'b1;

      // lw, ack on first BUSY cycle.
      sb.push_back(mk(1, 32'hDEADBEEF, 2'b00, 3'b000));
      do_req(0, 32'h0000_1004, 0, 3'b000, 1, 32'hDEADBEEF, 4'b1111, 32'h0);

      // Stores: no load result expected.
      do_req(1, 32'h0000_2003, 32'h0000_00A5, 3'b001, 1, 0, 4'b1000, 32'hA5A5A5A5);
      do_req(1, 32'h0000_2002, 32'h0000_1234, 3'b011, 2, 0, 4'b1100, 32'h12341234);
      do_req(1, 32'h0000_2000, 32'hFFFF_5678, 3'b100, 1, 0, 4'b0011, 32'h56785678);
      do_req(1, 32'h0000_2001, 32'h0000_003C, 3'b010, 1, 0, 4'b0010, 32'h3C3C3C3C);
      do_req(1, 32'h0000_2008, 32'hCAFEF00D, 3'b000, 3, 0, 4'b1111, 32'hCAFEF00D);
      chk("ld_hold", ld_data, 32'hDEADBEEF);

      // Misaligned.
      sb.push_back(mk(2, 0, 0, 0));
      do_mis(0, 32'h0000_3001, 3'b100);
      sb.push_back(mk(3, 0, 0, 0));
      do_mis(1, 32'h0000_3002, 3'b000);
      sb.push_back(mk(2, 0, 0, 0));
      do_mis(0, 32'h0000_3003, 3'b000);

      // Wait states: lbu, ack on 5th BUSY cycle.
      sb.push_back(mk(1, 32'h1122_3344, 2'b10, 3'b001));
      do_req(0, 32'h0000_4002, 0, 3'b001, 5, 32'h1122_3344, 4'b1111, 32'h0);
      // Aligned half load at offset 2.
      sb.push_back(mk(1, 32'h8001_7FFE, 2'b10, 3'b100));
      do_req(0, 32'h0000_4006, 0, 3'b100, 2, 32'h8001_7FFE, 4'b1111, 32'h0);

      // Timeout with no ack.
      sb.push_back(mk(4, 0, 0, 0));
      do_req(0, 32'h0000_5000, 0, 3'b000, 0, 0, 4'b1111, 32'h0);
      chk("to_ld_hold", ld_data, 32'h8001_7FFE);

      // Ack on the last permitted cycle wins over timeout.
      sb.push_back(mk(1, 32'h0BAD_F00D, 2'b00, 3'b000));
      do_req(0, 32'h0000_5004, 0, 3'b000, TO, 32'h0BAD_F00D, 4'b1111, 32'h0);

      // Reset in the middle of BUSY.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_6000; req_op = 3'b000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_req", mif.bus_req, 1);
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", mif.bus_req, 0);
      chk("mid_rst_addr", mif.bus_addr, 0);
      chk("mid_rst_ld_data", ld_data, 0);
      chk("mid_rst_stall", stall, 0);
      mif.bus_ack = 1'b1; mif.bus_rdata = 32'hFEEDFACE;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req", mif.bus_req, 0);
      @(posedge clk); #1;
      mif.bus_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_ld", ld_data, 0);

      // New load after reset completes normally.
      sb.push_back(mk(1, 32'h1357_9BDF, 2'b00, 3'b000));
      do_req(0, 32'h0000_7000, 0, 3'b000, 1, 32'h1357_9BDF, 4'b1111, 32'h0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_left", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit. It sits directly upstream of the load-data extender.
- Takes load/store requests from the pipeline, checks alignment, and generates word-aligned bus address, byte enables and replicated store data.
- Runs a req/ack handshake to data memory and stalls the pipeline until the handshake completes.
- Delivers the raw read word plus byte offset and extend op to the extender.

Parameters:
- TIMEOUT, 255, max BUSY cycles waiting for bus_ack before aborting (1..255).
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM stage holds a load/store.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_op  in  3  size/extend op: 000 word, 001 byte unsigned, 010 byte signed, 011 half unsigned, 100 half signed. Stores use size only.
- stall  out  1  hold pipeline (combinational).
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  32  {req_addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  memory completes the transfer this cycle.
- bus_rdata  in  32  read word, valid with bus_ack.
- ld_valid  out  1  one-cycle pulse: ld_data/ld_a/ld_op valid for the extender.
- ld_data  out  32  raw read word.
- ld_a  out  2  req_addr[1:0] of the load.
- ld_op  out  3  req_op of the load.
- adel  out  1  misaligned-load exception pulse.
- ades  out  1  misaligned-store exception pulse.
- bus_err  out  1  timeout abort pulse.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. bus_req, bus_we, ld_valid, adel, ades, bus_err = 0. bus_addr, bus_be, bus_wdata, ld_data, ld_a, ld_op = 0. Counter = 0.
- A reset mid-transaction drops bus_req immediately. A pending bus_ack is discarded.
- Size decode: op 000 = word; 001/010 = byte; 011/100 = half; 101–111 = treated as word.
- Alignment:
  - word requires addr[1:0]=00.
  - half requires addr[0]=0.
  - byte is always aligned.
- States: IDLE, BUSY, DONE.
- IDLE, req_valid=1, aligned:
  - Register bus_addr, bus_we, bus_be, bus_wdata, ld_a, ld_op.
  - Go to BUSY; bus_req=1 from the next cycle. Counter cleared.
- IDLE, req_valid=1, misaligned:
  - No bus access; state stays IDLE.
  - Next cycle: adel (load) or ades (store) pulses for exactly 1 cycle.
  - stall=0. The pipeline flushes; the unit does not re-check the same request while the pulse is high.
- IDLE, req_valid=0: no action.
- BUSY:
  - bus_req=1; address, be, we and wdata held stable.
  - Counter increments each cycle.
  - bus_ack=1 → drop bus_req next edge, go to DONE. For a load, capture bus_rdata into ld_data.
  - Counter reaches TIMEOUT-1 with no ack → drop bus_req, pulse bus_err, go to DONE with no ld_valid.
  - Ack in the same cycle as timeout → ack wins, bus_err not asserted.
- DONE:
  - ld_valid=1 for this single cycle if the transaction was a load with ack.
  - req_valid is ignored: it is still the completed instruction.
  - Return to IDLE.
- bus_ack outside BUSY is ignored.
- stall = (IDLE & req_valid & aligned) | BUSY. stall=0 in DONE.
- Latency: an aligned access with ack on the first BUSY cycle takes 3 cycles request-to-ld_valid (IDLE, BUSY, DONE); the pipeline is stalled for 2 cycles.
- Byte enables:
  - sw / any load: 1111.
  - sb: 0001 << addr[1:0].
  - sh: addr[1] ? 1100 : 0011.
- Store data:
  - sb: {4{wdata[7:0]}}.
  - sh: {2{wdata[15:0]}}.
  - sw: wdata.
  - Loads: bus_wdata = 0.
- ld_data, ld_a and ld_op hold their value until the next load completes.

Test Plan:
- Aligned load: lw addr 0x0000_1004, ack on 1st BUSY cycle with rdata 0xDEADBEEF → bus_addr 0x1004, be 1111, stall high 2 cycles, then ld_valid pulse with ld_data 0xDEADBEEF, ld_a 00, ld_op 000.
- Byte/half stores:
  - sb addr 0x2003, wdata 0x000000A5 → be 1000, bus_wdata 0xA5A5A5A5, bus_we 1.
  - sh addr 0x2002, wdata 0x1234 → be 1100, bus_wdata 0x12341234. No ld_valid in either case.
- Misaligned:
  - lh addr 0x3001 → adel pulses 1 cycle, bus_req never asserts, stall 0.
  - sw addr 0x3002 → ades pulses 1 cycle.
- Wait states and timeout:
  - lbu addr 0x4002, ack after 5 BUSY cycles → bus signals stable all 5 cycles; ld_a 10, ld_op 001.
  - With TIMEOUT=8 and no ack → bus_err pulse after 8 BUSY cycles, bus_req drops, stall releases, no ld_valid.
- Ack/timeout race: ack on exactly the TIMEOUT-th cycle → normal completion, bus_err 0.
- Reset mid-BUSY: rst_n low while bus_req=1 → bus_req 0 immediately, all outputs 0. Later ack ignored. A new lw after reset completes normally.
